// File: rtl/sequence_output_collector.sv
// sequence_output_collector
//   Final stage behind the 4-deep sequence input/compare chain. Removes the offset-binary bias
//   from each incoming element. Packs each group of N elements into one parallel frame and
//   flags a group that is not non-decreasing. Finished frames are queued in a 2-entry FIFO
//   behind a valid/ready handshake. The upstream chain cannot be stalled, so this block never
//   back-pressures. It instead reports a dropped frame (overflow) or a discarded partial group
//   (frag_err).
//
// Ports
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   in_valid       in_data carries an element this cycle
//   in_data        element from the last comparator stage (offset-binary if SIGNED_BIAS)
//   in_first       with in_valid: element starts a new group (slot 0)
//   out_valid      FIFO head frame valid
//   out_ready      consumer accepts the head frame
//   out_data       head frame, slot i in bits [i*DW +: DW]
//   out_order_err  head frame was not non-decreasing
//   frag_err       sticky: a partial group was discarded
//   overflow       sticky: a completed frame was dropped because the FIFO was full
//   frame_count    frames pushed into the FIFO, wraps at 16 bits
module sequence_output_collector #(
   parameter int unsigned DW          = 8,
   parameter int unsigned N           = 4,
   parameter bit          SIGNED_BIAS = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   input  logic            in_first,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*DW-1:0] out_data,
   output logic            out_order_err,
   output logic            frag_err,
   output logic            overflow,
   output logic [15:0]     frame_count
);

   localparam int unsigned CW = $clog2(N);

   logic [DW-1:0]   elem;
   logic [DW-1:0]   prev;
   logic [DW-1:0]   slot_q [N];
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   idx;
   logic            grp_err_q;
   logic            grp_err_d;
   logic            desc;
   logic [N*DW-1:0] frame;
   logic            push;
   logic            push_ok;
   logic            pop;
   logic            full;

   logic [N*DW-1:0] mem_data_q [2];
   logic [1:0]      mem_err_q;
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic            frag_err_q;
   logic            overflow_q;
   logic [15:0]     frame_count_q;

   always_comb begin
      elem = SIGNED_BIAS ? {~in_data[DW-1], in_data[DW-2:0]} : in_data;
      // in_first forces slot 0, abandoning whatever partial group is in progress
      idx  = in_first ? '0 : cnt_q;
      // at idx==0 this reads a wrapped slot, but the result is unused there
      prev = slot_q[idx - CW'(1)];
      desc = SIGNED_BIAS ? ($signed(elem) < $signed(prev)) : (elem < prev);
      grp_err_d = (idx == '0) ? 1'b0 : (grp_err_q | desc);
      // frame as it will look once the current element lands in its slot
      for (int i = 0; i < N; i++) begin
         frame[i*DW +: DW] = (CW'(i) == idx) ? elem : slot_q[i];
      end
      full    = (count_q == 2'd2);
      pop     = (count_q != 2'd0) && out_ready;
      push    = in_valid && (idx == CW'(N-1));
      // a full FIFO still takes a push when the head leaves on the same edge
      push_ok = push && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_err_q     <= '0;
         cnt_q         <= '0;
         grp_err_q     <= 1'b0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         frag_err_q    <= 1'b0;
         overflow_q    <= 1'b0;
         frame_count_q <= '0;
      end else begin
         if (in_valid) begin
            slot_q[idx] <= elem;
            cnt_q       <= idx + CW'(1);
            grp_err_q   <= grp_err_d;
            if (in_first && (cnt_q != '0)) frag_err_q <= 1'b1;
         end
         if (push_ok) begin
            mem_data_q[wr_ptr_q] <= frame;
            mem_err_q[wr_ptr_q]  <= grp_err_d;
            wr_ptr_q             <= ~wr_ptr_q;
            frame_count_q        <= frame_count_q + 16'd1;
         end else if (push) begin
            overflow_q <= 1'b1;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         unique case ({push_ok, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      out_valid     = (count_q != 2'd0);
      out_data      = mem_data_q[rd_ptr_q];
      out_order_err = mem_err_q[rd_ptr_q];
      frag_err      = frag_err_q;
      overflow      = overflow_q;
      frame_count   = frame_count_q;
   end

endmodule

// File: tb/tb_sequence_output_collector.sv
// Directed bench for sequence_output_collector (DW=8, N=4, SIGNED_BIAS=1).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sequence_output_collector;

   localparam int unsigned DW = 8;
   localparam int unsigned N  = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic            in_first = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [N*DW-1:0] out_data;
   logic            out_order_err;
   logic            frag_err;
   logic            overflow;
   logic [15:0]     frame_count;

   int checks = 0;
   int errors = 0;

   sequence_output_collector #(
      .DW(DW),
      .N(N),
      .SIGNED_BIAS(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_first(in_first),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_order_err(out_order_err),
      .frag_err(frag_err),
      .overflow(overflow),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one element per cycle; returns on the falling edge after the accepting edge
   task automatic send(input logic [7:0] d, input logic f);
      in_valid = 1'b1;
      in_data  = d;
      in_first = f;
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   // raw group, slot 0 in the low byte
   task automatic send_group(input logic [31:0] g, input logic f);
      send(g[7:0], f);
      send(g[15:8], 1'b0);
      send(g[23:16], 1'b0);
      send(g[31:24], 1'b0);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"}, 64'(out_valid), 64'd0);
      check({tag, ".data"}, 64'(out_data), 64'd0);
      check({tag, ".oerr"}, 64'(out_order_err), 64'd0);
      check({tag, ".frag"}, 64'(frag_err), 64'd0);
      check({tag, ".ovf"}, 64'(overflow), 64'd0);
      check({tag, ".fcnt"}, 64'(frame_count), 64'd0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // basic frame, bias removed, one cycle latency
      out_ready = 1'b1;
      send_group(32'h90_81_80_7E, 1'b1);
      check("f1.valid", 64'(out_valid), 64'd1);
      check("f1.data", 64'(out_data), 64'h10_01_00_FE);
      check("f1.oerr", 64'(out_order_err), 64'd0);
      check("f1.fcnt", 64'(frame_count), 64'd1);

      // descending pair inside the group
      send_group(32'h91_90_83_85, 1'b1);
      check("f2.data", 64'(out_data), 64'h11_10_03_05);
      check("f2.oerr", 64'(out_order_err), 64'd1);
      check("f2.fcnt", 64'(frame_count), 64'd2);

      // equal elements are legal
      send_group(32'h80_80_80_80, 1'b0);
      check("f3.data", 64'(out_data), 64'h0);
      check("f3.oerr", 64'(out_order_err), 64'd0);

      // -128,-1,0,127: ordered when signed, would fail unsigned
      send_group(32'hFF_80_7F_00, 1'b0);
      check("f4.data", 64'(out_data), 64'h7F_00_FF_80);
      check("f4.oerr", 64'(out_order_err), 64'd0);
      check("f4.fcnt", 64'(frame_count), 64'd4);
      @(negedge clk);
      check("f4.drain", 64'(out_valid), 64'd0);
      check("f4.frag", 64'(frag_err), 64'd0);

      // overflow: three frames, consumer stalled
      do_reset();
      out_ready = 1'b0;
      send_group(32'h84_83_82_81, 1'b1);
      send_group(32'h88_87_86_85, 1'b0);
      check("ovf.pre", 64'(overflow), 64'd0);
      send_group(32'h8C_8B_8A_89, 1'b0);
      check("ovf.flag", 64'(overflow), 64'd1);
      check("ovf.fcnt", 64'(frame_count), 64'd2);
      check("ovf.valid", 64'(out_valid), 64'd1);
      check("ovf.head", 64'(out_data), 64'h04_03_02_01);
      @(negedge clk);
      check("ovf.hold", 64'(out_data), 64'h04_03_02_01);
      out_ready = 1'b1;
      @(negedge clk);
      check("ovf.second", 64'(out_data), 64'h08_07_06_05);
      check("ovf.second_v", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("ovf.empty", 64'(out_valid), 64'd0);

      // push into a full FIFO with a simultaneous pop
      do_reset();
      out_ready = 1'b0;
      send_group(32'h84_83_82_81, 1'b1);
      send_group(32'h88_87_86_85, 1'b0);
      send(8'h89, 1'b0);
      send(8'h8A, 1'b0);
      send(8'h8B, 1'b0);
      check("pp.head", 64'(out_data), 64'h04_03_02_01);
      out_ready = 1'b1;
      send(8'h8C, 1'b0);
      check("pp.ovf", 64'(overflow), 64'd0);
      check("pp.fcnt", 64'(frame_count), 64'd3);
      check("pp.f2", 64'(out_data), 64'h08_07_06_05);
      @(negedge clk);
      check("pp.f3", 64'(out_data), 64'h0C_0B_0A_09);
      check("pp.f3_v", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("pp.empty", 64'(out_valid), 64'd0);

      // fragment discarded on early in_first
      do_reset();
      send(8'h81, 1'b1);
      send(8'h82, 1'b0);
      send(8'h90, 1'b1);
      check("frag.flag", 64'(frag_err), 64'd1);
      check("frag.nov", 64'(out_valid), 64'd0);
      send(8'h91, 1'b0);
      send(8'h92, 1'b0);
      send(8'h93, 1'b0);
      check("frag.valid", 64'(out_valid), 64'd1);
      check("frag.data", 64'(out_data), 64'h13_12_11_10);
      check("frag.fcnt", 64'(frame_count), 64'd1);

      // reset in the middle of a group
      send(8'h90, 1'b1);
      send(8'h91, 1'b0);
      send(8'h92, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      rst_n = 1'b1;
      send_group(32'h84_83_82_81, 1'b0);
      check("post.valid", 64'(out_valid), 64'd1);
      check("post.data", 64'(out_data), 64'h04_03_02_01);
      check("post.fcnt", 64'(frame_count), 64'd1);
      check("post.frag", 64'(frag_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
